vec_trace_mlane: RTL



---
 rtl/vec_trace_mlane.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vec_trace_mlane.sv
// vec_trace_mlane: multi-lane register-file writeback tracer.
// Snoops NLANES write ports and queues every non-zero-address writeback in a
// per-lane FIFO. The FIFOs drain round-robin through one registered
// valid/ready port. The pipe is stalled while any lane FIFO is nearly full.
// Optional build macro VEC_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp to
// each entry, presented on tr_time.
module vec_trace_mlane #(
  parameter int NLANES      = 4,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int DEPTH       = 64,
  parameter int ALMOST_FULL = 60,
  localparam int LW         = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 activated,
  input  logic [NLANES-1:0]    lane_we,
  input  logic [NLANES*AW-1:0] lane_addr,
  input  logic [NLANES*DW-1:0] lane_data,
  input  logic                 pipestalled,
  output logic                 stallpipe,
  output logic                 tr_valid,
  input  logic                 tr_ready,
  output logic [LW-1:0]        tr_lane,
  output logic [AW-1:0]        tr_addr,
  output logic [DW-1:0]        tr_data,
`ifdef VEC_TRACE_TIMESTAMP_EN
  output logic [31:0]          tr_time,
`endif
  output logic                 overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef VEC_TRACE_TIMESTAMP_EN
  localparam int EW = 32 + AW + DW;
`else
  localparam int EW = AW + DW;
`endif
  localparam logic [CW-1:0] AF_C   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic            stallpipe_q, stallpipe_d;

  logic [EW-1:0]   fifo_mem_q [NLANES][DEPTH];
  logic [PW-1:0]   wr_ptr_q [NLANES];
  logic [PW-1:0]   wr_ptr_d [NLANES];
  logic [PW-1:0]   rd_ptr_q [NLANES];
  logic [PW-1:0]   rd_ptr_d [NLANES];
  logic [CW-1:0]   count_q  [NLANES];
  logic [CW-1:0]   count_d  [NLANES];
  logic [LW-1:0]   rr_q, rr_d;

  logic            tr_valid_q, tr_valid_d;
  logic [LW-1:0]   tr_lane_q, tr_lane_d;
  logic [AW-1:0]   tr_addr_q, tr_addr_d;
  logic [DW-1:0]   tr_data_q, tr_data_d;
  logic            overflow_q, overflow_d;

`ifdef VEC_TRACE_TIMESTAMP_EN
  logic [31:0]     ts_q, ts_d;
  logic [31:0]     tr_time_q, tr_time_d;
`endif

  logic [NLANES-1:0] nonempty, full, near_full;
  logic [NLANES-1:0] push_req, push_ok, pop;
  logic [EW-1:0]     push_entry [NLANES];
  logic [EW-1:0]     sel_entry;
  logic [LW:0]       scan_j;
  logic [LW-1:0]     scan_lane;
  logic [LW-1:0]     sel;
  logic              found;
  logic              any_nonempty;
  logic              load;
  logic              capture_en;

  // Per-lane occupancy flags, all taken from the registered counts.
  always_comb begin
    nonempty  = '0;
    full      = '0;
    near_full = '0;
    for (int i = 0; i < NLANES; i++) begin
      nonempty[i]  = (count_q[i] != '0);
      full[i]      = (count_q[i] == FULL_C);
      near_full[i] = (count_q[i] >= AF_C);
    end
    any_nonempty = |nonempty;
    capture_en   = activated & ~pipestalled & (state_q == S_RUN);
  end

  // Capture qualification and entry packing for every snooped port.
  always_comb begin
    push_req = '0;
    push_ok  = '0;
    for (int i = 0; i < NLANES; i++) begin
      push_req[i] = lane_we[i] & (lane_addr[i*AW +: AW] != '0) & capture_en;
      push_ok[i]  = push_req[i] & ~full[i];
`ifdef VEC_TRACE_TIMESTAMP_EN
      push_entry[i] = {ts_q, lane_addr[i*AW +: AW], lane_data[i*DW +: DW]};
`else
      push_entry[i] = {lane_addr[i*AW +: AW], lane_data[i*DW +: DW]};
`endif
    end
  end

  // Round-robin pick: first non-empty lane at or above the RR pointer.
  always_comb begin
    sel       = '0;
    found     = 1'b0;
    scan_j    = '0;
    scan_lane = '0;
    for (int k = 0; k < NLANES; k++) begin
      scan_j = {1'b0, rr_q} + (LW+1)'(k);
      if (scan_j >= (LW+1)'(NLANES)) begin
        scan_j = scan_j - (LW+1)'(NLANES);
      end
      scan_lane = scan_j[LW-1:0];
      if (!found && nonempty[scan_lane]) begin
        found = 1'b1;
        sel   = scan_lane;
      end
    end
    load      = (~tr_valid_q | tr_ready) & any_nonempty;
    sel_entry = fifo_mem_q[sel][rd_ptr_q[sel]];
    pop       = '0;
    rr_d      = rr_q;
    if (load) begin
      pop[sel] = 1'b1;
      if (sel == LW'(NLANES - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = sel + LW'(1);
      end
    end
  end

  // FIFO pointer and occupancy updates; simultaneous push and pop keep the count.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      wr_ptr_d[i] = push_ok[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]     ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
      case ({push_ok[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // Output register: load a new entry when free or being accepted, else hold.
  always_comb begin
    tr_valid_d = tr_valid_q;
    tr_lane_d  = tr_lane_q;
    tr_addr_d  = tr_addr_q;
    tr_data_d  = tr_data_q;
`ifdef VEC_TRACE_TIMESTAMP_EN
    tr_time_d  = tr_time_q;
    ts_d       = activated ? ts_q + 32'd1 : ts_q;
`endif
    if (load) begin
      tr_valid_d = 1'b1;
      tr_lane_d  = sel;
      tr_addr_d  = sel_entry[DW +: AW];
      tr_data_d  = sel_entry[DW-1:0];
`ifdef VEC_TRACE_TIMESTAMP_EN
      tr_time_d  = sel_entry[AW+DW +: 32];
`endif
    end else if (tr_ready) begin
      tr_valid_d = 1'b0;
    end
    overflow_d = overflow_q | (|(push_req & full));
  end

  // Stall FSM: enter drain on near-full, leave once everything has been delivered.
  always_comb begin
    state_d     = state_q;
    stallpipe_d = stallpipe_q;
    case (state_q)
      S_RUN: begin
        stallpipe_d = 1'b0;
        if (activated & ~pipestalled & (|near_full)) begin
          state_d     = S_DRAIN;
          stallpipe_d = 1'b1;
        end
      end
      S_DRAIN: begin
        stallpipe_d = 1'b1;
        if (~any_nonempty & (~tr_valid_q | tr_ready)) begin
          state_d     = S_RUN;
          stallpipe_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_RUN;
        stallpipe_d = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (push_ok[i]) begin
        fifo_mem_q[i][wr_ptr_q[i]] <= push_entry[i];
      end
    end
  end

  // Control and output state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RUN;
      stallpipe_q <= 1'b0;
      rr_q        <= '0;
      tr_valid_q  <= 1'b0;
      tr_lane_q   <= '0;
      tr_addr_q   <= '0;
      tr_data_q   <= '0;
      overflow_q  <= 1'b0;
`ifdef VEC_TRACE_TIMESTAMP_EN
      ts_q        <= '0;
      tr_time_q   <= '0;
`endif
      for (int i = 0; i < NLANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      stallpipe_q <= stallpipe_d;
      rr_q        <= rr_d;
      tr_valid_q  <= tr_valid_d;
      tr_lane_q   <= tr_lane_d;
      tr_addr_q   <= tr_addr_d;
      tr_data_q   <= tr_data_d;
      overflow_q  <= overflow_d;
`ifdef VEC_TRACE_TIMESTAMP_EN
      ts_q        <= ts_d;
      tr_time_q   <= tr_time_d;
`endif
      for (int i = 0; i < NLANES; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  assign stallpipe = stallpipe_q;
  assign tr_valid  = tr_valid_q;
  assign tr_lane   = tr_lane_q;
  assign tr_addr   = tr_addr_q;
  assign tr_data   = tr_data_q;
  assign overflow  = overflow_q;
`ifdef VEC_TRACE_TIMESTAMP_EN
  assign tr_time   = tr_time_q;
`endif

endmodule
